// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared constants for the nibble-serial adder controller
//
// Purpose: state encoding of the controller FSM and the width of one adder slice.
// Ports:   none (package).
package serial_adder_ctrl_pkg;

  // Width of the single adder slice that is stepped across the operands.
  localparam int NIBBLE_W = 4;

  // Controller states (kept as plain 2-bit constants for legacy tooling).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_nibble_adder.sv
// rtl/serial_adder_ctrl_nibble_adder.sv - 4-bit ripple adder slice with carry-in
//
// Purpose: full_adder is the one-bit cell; nibble_adder_ci chains NIBBLE_W of
//          them into the ripple slice that the controller reuses on every pass.
// Ports (full_adder):      a, b, ci -> s, co
// Ports (nibble_adder_ci): a[3:0], b[3:0], ci -> s[3:0], c (carry out of bit 3)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module nibble_adder_ci
  import serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                c
);

  // chain[i] is the carry into bit i; chain[NIBBLE_W] leaves the slice.
  logic [NIBBLE_W:0] chain;

  assign chain[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (chain[i]),
      .s  (s[i]),
      .co (chain[i+1])
    );
  end

  assign c = chain[NIBBLE_W];

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - WIDTH-bit add/subtract sequenced one nibble per clock
//
// Purpose: accepts operands over a valid/ready handshake, steps one shared
//          4-bit adder slice across them LSB nibble first, and presents the
//          registered result with carry and signed-overflow flags.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start_valid / start_ready  operand handshake (ready only in IDLE)
//   a, b, sub                  operands and operation select, captured on accept
//   res_valid / res_ready      result handshake (valid only in DONE)
//   sum, carryout, overflow    registered result and flags
//   busy                       high while passes are running
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_c;

  assign start_ready = (state == ST_IDLE);
  assign busy        = (state == ST_RUN);
  assign res_valid   = (state == ST_DONE);

  assign nib_a = opa[NIBBLE_W*idx +: NIBBLE_W];
  assign nib_b = opb[NIBBLE_W*idx +: NIBBLE_W];

  nibble_adder_ci u_nibble (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .s  (nib_s),
    .c  (nib_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
            opa      <= a;
            opb      <= sub ? ~b : b;
            carry    <= sub;
            idx      <= '0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum[NIBBLE_W*idx +: NIBBLE_W] <= nib_s;
          carry <= nib_c;
          if (idx == LAST_IDX) begin
            carryout <= nib_c;
            // Signed overflow: like-signed operands (after b inversion) giving
            // a result MSB that differs from them.
            overflow <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                        (nib_s[NIBBLE_W-1] != opa[WIDTH-1]);
            idx      <= '0;
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] sum;
  logic        carryout;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .carryout    (carryout),
    .overflow    (overflow),
    .busy        (busy)
  );

  // Reference: plain integer arithmetic on the full-width operation.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic msub,
                       output logic [15:0] es, output logic ec, output logic eo);
    int ua, ub, sa, sb, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      es = 16'(ua - ub);
      ec = (ua >= ub);
      sr = sa - sb;
    end else begin
      es = 16'(ua + ub);
      ec = (ua + ub) > 65535;
      sr = sa + sb;
    end
    eo = (sr > 32767) || (sr < -32768);
  endtask

  // Presents one operation, then scrambles the inputs after the accepting
  // edge and counts cycles until res_valid (bounded).
  task automatic start_and_wait(input logic [15:0] ia, input logic [15:0] ib,
                                input logic isub, output int lat);
    @(negedge clk);
    a = ia; b = ib; sub = isub; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({start_ready, busy, res_valid, carryout, overflow} !== 5'b10000 || sum !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b busy=%b vld=%b co=%b ov=%b sum=%h, required 1 0 0 0 0 0000",
               start_ready, busy, res_valid, carryout, overflow, sum);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vsub;
    logic [15:0] vsum;
    logic        vco;
    logic        vov;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[5];
    int lat;
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    foreach (tbl[i]) begin
      start_and_wait(tbl[i].va, tbl[i].vb, tbl[i].vsub, lat);
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, required 4", i, lat);
      end
      checks++;
      if (sum !== tbl[i].vsum || carryout !== tbl[i].vco || overflow !== tbl[i].vov) begin
        failures++;
        $display("FAIL directed_result[%0d]: sum=%h co=%b ov=%b, required sum=%h co=%b ov=%b",
                 i, sum, carryout, overflow, tbl[i].vsum, tbl[i].vco, tbl[i].vov);
      end
      consume();
      checks++;
      if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
        failures++;
        $display("FAIL directed_release[%0d]: rdy=%b vld=%b, required 1 0", i, start_ready, res_valid);
      end
    end
  endtask

  task automatic test_hold_done();
    int lat;
    logic [15:0] es;
    logic ec, eo;
    model(16'h9ABC, 16'h1357, 1'b1, es, ec, eo);
    start_and_wait(16'h9ABC, 16'h1357, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b0 ||
          sum !== es || carryout !== ec || overflow !== eo) begin
        failures++;
        $display("FAIL hold_done[%0d]: vld=%b rdy=%b busy=%b sum=%h co=%b ov=%b, required 1 0 0 %h %b %b",
                 i, res_valid, start_ready, busy, sum, carryout, overflow, es, ec, eo);
      end
      start_valid = i[0];
      a = 16'($urandom); b = 16'($urandom);
    end
    @(negedge clk);
    start_valid = 1'b0;
    consume();
    checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || sum !== es) begin
      failures++;
      $display("FAIL hold_release: rdy=%b vld=%b sum=%h, required 1 0 %h", start_ready, res_valid, sum, es);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_no_queue: busy=%b rdy=%b, required 0 1", busy, start_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] es;
    logic ec, eo;
    start_and_wait(16'h0F0F, 16'h0101, 1'b0, lat);
    @(negedge clk);
    res_ready = 1'b1; start_valid = 1'b1;
    a = 16'h8001; b = 16'h7FFF; sub = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_not_accepted_in_done: busy=%b rdy=%b, required 0 1", busy, start_ready);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept_in_idle: busy=%b, required 1", busy);
    end
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    model(16'h8001, 16'h7FFF, 1'b1, es, ec, eo);
    checks++;
    if (lat !== 4 || sum !== es || carryout !== ec || overflow !== eo) begin
      failures++;
      $display("FAIL b2b_result: lat=%0d sum=%h co=%b ov=%b, required 4 %h %b %b",
               lat, sum, carryout, overflow, es, ec, eo);
    end
    consume();
  endtask

  task automatic test_reset_abort();
    int lat;
    bit saw_valid;
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({start_ready, busy, res_valid, carryout, overflow} !== 5'b10000 || sum !== 16'h0) begin
      failures++;
      $display("FAIL abort_async: rdy=%b busy=%b vld=%b co=%b ov=%b sum=%h, required 1 0 0 0 0 0000",
               start_ready, busy, res_valid, carryout, overflow, sum);
    end
    saw_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) saw_valid = 1;
      if (i == 2) reset = 1'b0;
    end
    checks++;
    if (saw_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_valid: saw_valid=%b busy=%b, required 0 0", saw_valid, busy);
    end
    start_and_wait(16'h00FF, 16'h0001, 1'b0, lat);
    checks++;
    if (lat !== 4 || sum !== 16'h0100 || carryout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL abort_next_op: lat=%0d sum=%h co=%b ov=%b, required 4 0100 0 0",
               lat, sum, carryout, overflow);
    end
    consume();
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] ra, rb, es;
    logic rs, ec, eo;
    for (int n = 0; n < 60; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 8 == 0) rb = ra;
      rs = 1'($urandom);
      model(ra, rb, rs, es, ec, eo);
      start_and_wait(ra, rb, rs, lat);
      checks++;
      if (lat !== 4 || sum !== es || carryout !== ec || overflow !== eo) begin
        failures++;
        $display("FAIL random[%0d] %h %s %h: lat=%0d sum=%h co=%b ov=%b, required 4 %h %b %b",
                 n, ra, rs ? "-" : "+", rb, lat, sum, carryout, overflow, es, ec, eo);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_done();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
